// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and default widths for the Wishbone round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, ABORT)
//   WB_*        : default bus geometry and watchdog limit
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int WB_NUM_MASTERS    = 2;
  localparam int WB_ADDR_WIDTH     = 32;
  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of every Wishbone signal around the arbiter.
//   M_* : per-master request side (packed [NUM_MASTERS] arrays) and the returned DAT/ACK/ERR
//   S_* : single shared slave port
// Modports:
//   master : the environment -- requesters plus the slave device; drives requests, S_DAT_O, S_ACK_O
//   slave  : the arbiter itself; serves the requesters and drives the shared slave port
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = wb_rr_arbiter_pkg::WB_NUM_MASTERS,
  parameter int ADDR_WIDTH  = wb_rr_arbiter_pkg::WB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = wb_rr_arbiter_pkg::WB_DATA_WIDTH
);
  logic [NUM_MASTERS-1:0]                   M_CYC_O;
  logic [NUM_MASTERS-1:0]                   M_STB_O;
  logic [NUM_MASTERS-1:0]                   M_WE_O;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   M_ADR_O;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   M_DAT_O;
  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] M_SEL_O;
  logic [DATA_WIDTH-1:0]                    M_DAT_I;
  logic [NUM_MASTERS-1:0]                   M_ACK_I;
  logic [NUM_MASTERS-1:0]                   M_ERR_I;

  logic                    S_CYC_I;
  logic                    S_STB_I;
  logic                    S_WE_I;
  logic [ADDR_WIDTH-1:0]   S_ADR_I;
  logic [DATA_WIDTH-1:0]   S_DAT_I;
  logic [DATA_WIDTH/8-1:0] S_SEL_I;
  logic [DATA_WIDTH-1:0]   S_DAT_O;
  logic                    S_ACK_O;

  modport master (
    output M_CYC_O, M_STB_O, M_WE_O, M_ADR_O, M_DAT_O, M_SEL_O, S_DAT_O, S_ACK_O,
    input  M_DAT_I, M_ACK_I, M_ERR_I, S_CYC_I, S_STB_I, S_WE_I, S_ADR_I, S_DAT_I, S_SEL_I
  );

  modport slave (
    input  M_CYC_O, M_STB_O, M_WE_O, M_ADR_O, M_DAT_O, M_SEL_O, S_DAT_O, S_ACK_O,
    output M_DAT_I, M_ACK_I, M_ERR_I, S_CYC_I, S_STB_I, S_WE_I, S_ADR_I, S_DAT_I, S_SEL_I
  );
endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   last_i  : index of the previous winner
//   valid_o : at least one request present
//   idx_o   : first requester found scanning last_i+1, last_i+2, ... modulo NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // cand[gi] is the index visited at scan step gi+1; the wrap is an explicit
  // subtract so non-power-of-2 counts never land on an unused index.
  logic [IDX_W-1:0] cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum       = {1'b0, last_i} + (IDX_W+1)'(gi + 1);
      assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                       : sum[IDX_W-1:0];
    end
  endgenerate

  // Walk from the farthest candidate to the nearest so the nearest hit is
  // the last assignment and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        valid_o = 1'b1;
        idx_o   = cand[k];
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS requesters share one slave port.
// A master owns the bus for its whole CYC; a watchdog aborts beats that wait
// TIMEOUT_CYCLES without ACK.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : Wishbone bundle (arbiter side, slave modport)
//   gnt_o  : one-hot current owner, zero outside GRANT
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = WB_NUM_MASTERS,
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_rr_arbiter_if.slave         bus,
  output logic [NUM_MASTERS-1:0] gnt_o
);

  localparam int IW     = $clog2(NUM_MASTERS);
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t             state_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          last_q;
  logic [WDOG_W-1:0]      wdog_q;
  logic [WDOG_W-1:0]      wdog_d;
  logic [NUM_MASTERS-1:0] gnt_q;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IW)
  ) u_pick (
    .req_i   (bus.M_CYC_O),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  logic in_grant, own_cyc, own_stb, stall, timeout;

  assign in_grant = (state_q == GRANT);
  assign own_cyc  = bus.M_CYC_O[owner_q];
  assign own_stb  = bus.M_STB_O[owner_q];
  assign stall    = in_grant && own_cyc && own_stb && !bus.S_ACK_O;
  // An ACK in the final watchdog cycle clears stall, so ACK beats timeout.
  assign timeout  = stall && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if (stall && !timeout) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      wdog_q  <= '0;
      gnt_q   <= '0;
    end else begin
      wdog_q <= wdog_d;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_idx;
            gnt_q   <= NUM_MASTERS'(1) << pick_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!own_cyc) begin
            last_q  <= owner_q;
            gnt_q   <= '0;
            state_q <= IDLE;
          end else if (timeout) begin
            gnt_q   <= '0;
            state_q <= ABORT;
          end
        end
        ABORT: begin
          if (!own_cyc) begin
            last_q  <= owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: everything is zero unless GRANT; the owner's strobe is cut in
  // the cycle the watchdog fires.
  always_comb begin
    bus.S_CYC_I = 1'b0;
    bus.S_STB_I = 1'b0;
    bus.S_WE_I  = 1'b0;
    bus.S_ADR_I = '0;
    bus.S_DAT_I = '0;
    bus.S_SEL_I = '0;
    bus.M_DAT_I = '0;
    bus.M_ACK_I = '0;
    bus.M_ERR_I = '0;
    if (in_grant) begin
      bus.S_CYC_I = own_cyc && !timeout;
      bus.S_STB_I = own_stb && !timeout;
      bus.S_WE_I  = bus.M_WE_O[owner_q];
      bus.S_ADR_I = bus.M_ADR_O[owner_q];
      bus.S_DAT_I = bus.M_DAT_O[owner_q];
      bus.S_SEL_I = bus.M_SEL_O[owner_q];
      bus.M_DAT_I = bus.S_DAT_O;
      bus.M_ACK_I = bus.S_ACK_O ? gnt_q : '0;
      bus.M_ERR_I = timeout ? gnt_q : '0;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (3 masters, watchdog limit 8) with a
// behavioural model compared on every falling edge plus literal checks.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int T  = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic         clk;
  logic         rst_i;
  logic [N-1:0] gnt_o;

  wb_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus),
    .gnt_o (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = no owner, 1 = owner holds the bus, 2 = owner aborted
  int m_phase = 0;
  int m_owner = 0;
  int m_last  = N - 1;
  int m_stall = 0;   // stalled cycles already completed in the current beat

  function automatic int next_owner(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_phase <= 0;
      m_owner <= 0;
      m_last  <= N - 1;
      m_stall <= 0;
    end else if (m_phase == 0) begin
      if (next_owner(m_last, bus.M_CYC_O) >= 0) begin
        m_phase <= 1;
        m_owner <= next_owner(m_last, bus.M_CYC_O);
        m_stall <= 0;
      end
    end else if (m_phase == 1) begin
      if (!bus.M_CYC_O[m_owner]) begin
        m_last  <= m_owner;
        m_phase <= 0;
      end else if (bus.M_STB_O[m_owner] && !bus.S_ACK_O) begin
        if (m_stall + 1 == T) begin
          m_phase <= 2;
          m_stall <= 0;
        end else begin
          m_stall <= m_stall + 1;
        end
      end else begin
        m_stall <= 0;
      end
    end else begin
      if (!bus.M_CYC_O[m_owner]) begin
        m_last  <= m_owner;
        m_phase <= 0;
      end
    end
  end

  logic          e_to, e_cyc, e_stb, e_we;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat, e_mdat;
  logic [DW/8-1:0] e_sel;
  logic [N-1:0]  e_gnt, e_ack, e_err;

  always_comb begin
    e_to = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_mdat = '0; e_sel = '0;
    e_gnt = '0; e_ack = '0; e_err = '0;
    if (m_phase == 1) begin
      // the beat times out when this cycle would be its T-th stalled cycle
      e_to   = bus.M_CYC_O[m_owner] && bus.M_STB_O[m_owner] && !bus.S_ACK_O && (m_stall + 1 == T);
      e_gnt  = N'(1) << m_owner;
      e_cyc  = bus.M_CYC_O[m_owner] && !e_to;
      e_stb  = bus.M_STB_O[m_owner] && !e_to;
      e_we   = bus.M_WE_O[m_owner];
      e_adr  = bus.M_ADR_O[m_owner];
      e_dat  = bus.M_DAT_O[m_owner];
      e_sel  = bus.M_SEL_O[m_owner];
      e_mdat = bus.S_DAT_O;
      e_ack  = bus.S_ACK_O ? e_gnt : '0;
      e_err  = e_to ? e_gnt : '0;
    end
  end

  always @(negedge clk) begin
    chk("gnt",  64'(gnt_o),       64'(e_gnt));
    chk("scyc", 64'(bus.S_CYC_I), 64'(e_cyc));
    chk("sstb", 64'(bus.S_STB_I), 64'(e_stb));
    chk("swe",  64'(bus.S_WE_I),  64'(e_we));
    chk("sadr", 64'(bus.S_ADR_I), 64'(e_adr));
    chk("sdat", 64'(bus.S_DAT_I), 64'(e_dat));
    chk("ssel", 64'(bus.S_SEL_I), 64'(e_sel));
    chk("mdat", 64'(bus.M_DAT_I), 64'(e_mdat));
    chk("mack", 64'(bus.M_ACK_I), 64'(e_ack));
    chk("merr", 64'(bus.M_ERR_I), 64'(e_err));
    if (bus.M_ACK_I != '0)
      $display("ack   gnt=%b we=%b adr=%h wdat=%h rdat=%h", gnt_o, bus.S_WE_I, bus.S_ADR_I,
               bus.S_DAT_I, bus.M_DAT_I);
    if (bus.M_ERR_I != '0)
      $display("abort err=%b adr=%h", bus.M_ERR_I, bus.M_ADR_O[m_owner]);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.M_CYC_O = '0;
    bus.M_STB_O = '0;
    bus.M_WE_O  = '0;
    bus.S_ACK_O = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.M_ADR_O[i] = AW'(32'h1000_0000 + 32'(i) * 32'h100);
      bus.M_DAT_O[i] = DW'(32'hA000_0000 + 32'(i));
      bus.M_SEL_O[i] = '1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 0, 1};

  initial begin
    rst_i = 1'b0;
    bus.S_DAT_O = 32'hCAFE_F00D;
    clear_inputs();
    #1 rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 64'(gnt_o), 64'd0);
    chk("reset_cyc", 64'(bus.S_CYC_I), 64'd0);

    // 1: single master write, ACK on the third granted cycle
    step();
    bus.M_CYC_O[0] = 1'b1; bus.M_STB_O[0] = 1'b1; bus.M_WE_O[0] = 1'b1;
    bus.M_ADR_O[0] = 32'h3000_0010; bus.M_DAT_O[0] = 32'hDEAD_BEEF;
    step();
    @(negedge clk);
    chk("t1_adr", 64'(bus.S_ADR_I), 64'h3000_0010);
    chk("t1_dat", 64'(bus.S_DAT_I), 64'hDEAD_BEEF);
    chk("t1_gnt", 64'(gnt_o), 64'b001);
    step();
    step();
    bus.S_ACK_O = 1'b1;
    @(negedge clk);
    chk("t1_ack", 64'(bus.M_ACK_I), 64'b001);
    chk("t1_rdat", 64'(bus.M_DAT_I), 64'hCAFE_F00D);
    step();
    bus.S_ACK_O = 1'b0; bus.M_CYC_O[0] = 1'b0; bus.M_STB_O[0] = 1'b0; bus.M_WE_O[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_end", 64'(bus.M_ACK_I), 64'b000);
    step();

    // 2: simultaneous requests from reset -> 0, idle gap, 1
    clear_inputs();
    do_reset();
    bus.M_CYC_O = 3'b011; bus.M_STB_O = 3'b011;
    step();
    @(negedge clk);
    chk("t2_gnt_first", 64'(gnt_o), 64'b001);
    step();
    bus.S_ACK_O = 1'b1;
    @(negedge clk);
    chk("t2_ack0", 64'(bus.M_ACK_I), 64'b001);
    step();
    bus.S_ACK_O = 1'b0; bus.M_CYC_O[0] = 1'b0; bus.M_STB_O[0] = 1'b0;
    step();
    @(negedge clk);
    chk("t2_gnt_gap", 64'(gnt_o), 64'b000);
    step();
    @(negedge clk);
    chk("t2_gnt_second", 64'(gnt_o), 64'b010);
    chk("t2_adr1", 64'(bus.S_ADR_I), 64'h1000_0100);
    step();
    bus.S_ACK_O = 1'b1;
    @(negedge clk);
    chk("t2_ack1", 64'(bus.M_ACK_I), 64'b010);
    step();
    bus.S_ACK_O = 1'b0; bus.M_CYC_O = '0; bus.M_STB_O = '0;
    step();

    // 3: master 0 holds four beats while master 1 waits
    clear_inputs();
    do_reset();
    bus.M_CYC_O = 3'b011; bus.M_STB_O = 3'b011;
    step();
    @(negedge clk);
    chk("t3_gnt_start", 64'(gnt_o), 64'b001);
    for (int b = 0; b < 4; b++) begin
      step();
      bus.S_ACK_O = 1'b1;
      @(negedge clk);
      chk("t3_ack_owner_only", 64'(bus.M_ACK_I), 64'b001);
      chk("t3_gnt_held", 64'(gnt_o), 64'b001);
    end
    step();
    bus.S_ACK_O = 1'b0; bus.M_CYC_O[0] = 1'b0; bus.M_STB_O[0] = 1'b0;
    step();
    @(negedge clk);
    chk("t3_gnt_gap", 64'(gnt_o), 64'b000);
    step();
    @(negedge clk);
    chk("t3_gnt_switch", 64'(gnt_o), 64'b010);
    step();
    bus.M_CYC_O = '0; bus.M_STB_O = '0;
    step();

    // 4: watchdog, master 2, slave never ACKs
    clear_inputs();
    do_reset();
    bus.M_CYC_O[2] = 1'b1; bus.M_STB_O[2] = 1'b1;
    for (int i = 1; i <= T; i++) begin
      step();
      @(negedge clk);
      chk("t4_err", 64'(bus.M_ERR_I), (i == T) ? 64'b100 : 64'b000);
      if (i == T) chk("t4_cyc_cut", 64'(bus.S_CYC_I), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("t4_abort_gnt", 64'(gnt_o), 64'b000);
      chk("t4_abort_cyc", 64'(bus.S_CYC_I), 64'd0);
      chk("t4_abort_err", 64'(bus.M_ERR_I), 64'b000);
    end
    step();
    bus.M_CYC_O[2] = 1'b0; bus.M_STB_O[2] = 1'b0;
    step();
    bus.M_CYC_O[0] = 1'b1; bus.M_STB_O[0] = 1'b1;
    step();
    @(negedge clk);
    chk("t4_after_abort", 64'(gnt_o), 64'b001);
    step();
    bus.M_CYC_O = '0; bus.M_STB_O = '0;
    step();

    // 5: three masters request continuously, one beat each
    clear_inputs();
    do_reset();
    bus.M_CYC_O = 3'b111; bus.M_STB_O = 3'b111;
    for (int t = 0; t < 5; t++) begin
      int got;
      got = -1;
      for (int w = 0; w < 10 && got < 0; w++) begin
        step();
        @(negedge clk);
        for (int k = 0; k < N; k++) if (gnt_o == (N'(1) << k)) got = k;
      end
      if (got < 0) begin
        chk("t5_grant_wait", 64'(gnt_o), 64'(N'(1) << exp_order[t]));
      end else begin
        chk("t5_order", 64'(got), 64'(exp_order[t]));
        step();
        bus.S_ACK_O = 1'b1;
        step();
        bus.S_ACK_O = 1'b0; bus.M_CYC_O[got] = 1'b0; bus.M_STB_O[got] = 1'b0;
        step();
        bus.M_CYC_O[got] = 1'b1; bus.M_STB_O[got] = 1'b1;
      end
    end
    bus.M_CYC_O = '0; bus.M_STB_O = '0;
    step();
    step();

    // 6: asynchronous reset in the middle of a beat
    clear_inputs();
    do_reset();
    bus.M_CYC_O[1] = 1'b1; bus.M_STB_O[1] = 1'b1;
    step();
    @(negedge clk);
    chk("t6_gnt_before", 64'(gnt_o), 64'b010);
    chk("t6_cyc_before", 64'(bus.S_CYC_I), 64'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("t6_cyc_async", 64'(bus.S_CYC_I), 64'd0);
    chk("t6_gnt_async", 64'(gnt_o), 64'b000);
    step();
    step();
    bus.M_CYC_O = 3'b011; bus.M_STB_O = 3'b011;
    rst_i = 1'b0;
    step();
    @(negedge clk);
    chk("t6_first_after_reset", 64'(gnt_o), 64'b001);
    step();
    bus.M_CYC_O = '0; bus.M_STB_O = '0;
    step();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
